rx_fifo_arbiter: RTL and testbench
==================================

Name: rx_fifo_arbiter

Overview:
Shares the single 8-bit rx FIFO write port between two byte producers: port 0 is the SD-card block reader and port 1 is the host/config byte path. Arbitration is round-robin with burst locking, so one requester's bytes stay contiguous in the FIFO. Each requester sees a valid/ready handshake. The arbiter drives the FIFO's w_enable/w_data directly and back-pressures on full.

Parameters:
BURST_LEN, 16, maximum bytes granted to one port per grant (2..255).
CNT_W, 16, width of the optional statistics counters.

Ports:
clk  input  1  system clock, all logic on rising edge.
n_rst  input  1  synchronous, active-high reset: sampled on rising clk, a 1 resets.
req0_valid  input  1  port 0 has a byte.
req0_data  input  8  port 0 byte.
req0_last  input  1  port 0 byte is the end of its packet.
req0_ready  output  1  port 0 byte accepted this cycle when valid&ready.
req1_valid  input  1  port 1 has a byte.
req1_data  input  8  port 1 byte.
req1_last  input  1  port 1 end of packet.
req1_ready  output  1  port 1 accept.
fifo_full  input  1  FIFO full flag.
fifo_w_enable  output  1  FIFO write strobe.
fifo_w_data  output  8  FIFO write data.
grant  output  2  one-hot current owner (00 = idle).
stat0_bytes  output  CNT_W  bytes written from port 0 (only with FIFO_ARB_STATS_EN).
stat1_bytes  output  CNT_W  bytes written from port 1 (only with FIFO_ARB_STATS_EN).

Behaviour:
- Reset values (n_rst=1 at an edge):
  - state=IDLE, grant=00, beat count=0, last_served=1 (port 0 wins first).
  - req*_ready=0, fifo_w_enable=0, fifo_w_data=0.
- States: IDLE, GRANT0, GRANT1. grant is registered and equals the state one-hot.
- Transitions out of IDLE:
  - Any valid seen: go to a GRANT state at the next edge (1-cycle arbitration latency).
  - Both valid: grant the port != last_served.
  - One valid: grant that port.
  - last_served is updated on entry to a GRANT state.
- Handshake (combinational):
  - reqN_ready = (state==GRANTN) & !fifo_full.
  - fifo_w_enable = reqN_valid & reqN_ready for the granted N.
  - fifo_w_data = granted port's data (0 when idle).
  - Ungranted port ready=0.
- Beat count:
  - Increments on each transfer.
  - Resets to 0 on leaving a GRANT state.
- Release from GRANTN back to IDLE at the next edge on any of:
  - A transfer with reqN_last=1.
  - A transfer that makes the beat count == BURST_LEN.
  - reqN_valid=0 while granted (no transfer that cycle).
- Release always passes through IDLE: one bubble cycle between grants.
- fifo_full=1 while granted: hold the grant, no transfer, beat count frozen. The requester must hold data stable.
- Simultaneous last and burst-limit on the same beat: a single release, same as either alone.
- Reset mid-burst: the grant is dropped immediately at that edge and no write is issued in the reset cycle (w_enable gated by !n_rst). The producer is responsible for resending the partial packet.
- fifo_full while IDLE: arbitration still proceeds, and the write waits in the GRANT state.

Optional Feature:
FIFO_ARB_STATS_EN:
- Defined:
  - stat0_bytes and stat1_bytes count transfers per port.
  - Counters saturate at all-ones and clear on reset.
- Undefined:
  - The ports are still present but tied to 0.
  - No counter flops are synthesized.

Test Plan:
- Reset, then port 0 sends 3 bytes 0xA1,0xA2,0xA3 (last on 0xA3), port 1 idle:
  - grant=01 one cycle after valid.
  - Three w_enable pulses with data A1,A2,A3.
  - grant=00 on the cycle after 0xA3.
- Both ports valid continuously, BURST_LEN=4, no last:
  - FIFO sees 4 bytes from port 0, one idle cycle, then 4 bytes from port 1, then 4 from port 0.
  - last_served alternates.
- Port 1 granted, fifo_full=1 for 5 cycles mid-burst:
  - req1_ready=0 and no writes during those cycles.
  - Grant held, beat count unchanged.
  - The remaining bytes are written after full drops.
- Port 0 granted, drops valid after 2 bytes:
  - Release to IDLE the next cycle.
  - A waiting port 1 is granted one cycle later.
- n_rst=1 asserted on the 3rd beat of a port 0 burst:
  - No write that cycle, grant=00.
  - After reset, with both ports valid, port 0 is granted first.
- FIFO_ARB_STATS_EN defined, port 0 sends 10 bytes and port 1 sends 7:
  - stat0_bytes=10, stat1_bytes=7.
  - Undefined: both read 0.

Source files
------------

// File: rtl/rx_fifo_arbiter_if.sv
// Handshake bundle between the two byte producers, the rx FIFO write port and the arbiter.
// The arbiter connects through the master modport; the producer/FIFO side uses slave.
interface rx_fifo_arbiter_if #(
    parameter int CNT_W = 16
);
    logic             req0_valid;
    logic [7:0]       req0_data;
    logic             req0_last;
    logic             req0_ready;
    logic             req1_valid;
    logic [7:0]       req1_data;
    logic             req1_last;
    logic             req1_ready;
    logic             fifo_full;
    logic             fifo_w_enable;
    logic [7:0]       fifo_w_data;
    logic [1:0]       grant;
    logic [CNT_W-1:0] stat0_bytes;
    logic [CNT_W-1:0] stat1_bytes;

    modport master (
        input  req0_valid, req0_data, req0_last,
        input  req1_valid, req1_data, req1_last,
        input  fifo_full,
        output req0_ready, req1_ready,
        output fifo_w_enable, fifo_w_data, grant,
        output stat0_bytes, stat1_bytes
    );

    modport slave (
        output req0_valid, req0_data, req0_last,
        output req1_valid, req1_data, req1_last,
        output fifo_full,
        input  req0_ready, req1_ready,
        input  fifo_w_enable, fifo_w_data, grant,
        input  stat0_bytes, stat1_bytes
    );
endinterface

// File: rtl/rx_fifo_arbiter.sv
// Round-robin, burst-locked arbiter sharing the rx FIFO write port between two byte producers.
// Optional per-port byte counters are enabled with the FIFO_ARB_STATS_EN macro.
module rx_fifo_arbiter #(
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    rx_fifo_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } state_t;

    localparam logic [7:0] BURST_LAST = 8'(BURST_LEN);

    state_t     state, state_nxt;
    logic [7:0] beat, beat_nxt, beat_inc;
    logic       last_served, last_served_nxt;
    logic       ready0, ready1, xfer;
    logic [7:0] wdata;

    assign beat_inc = beat + 8'd1;

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state       <= IDLE;
            beat        <= 8'd0;
            last_served <= 1'b1;
        end else begin
            state       <= state_nxt;
            beat        <= beat_nxt;
            last_served <= last_served_nxt;
        end
    end

    // Ready is also gated by reset so a byte is never consumed in a cycle whose write is dropped.
    always_comb begin
        state_nxt       = state;
        beat_nxt        = beat;
        last_served_nxt = last_served;
        ready0          = 1'b0;
        ready1          = 1'b0;
        xfer            = 1'b0;
        wdata           = 8'd0;
        case (state)
            IDLE: begin
                if (bus.req0_valid && (!bus.req1_valid || last_served)) begin
                    state_nxt       = GRANT0;
                    last_served_nxt = 1'b0;
                end else if (bus.req1_valid) begin
                    state_nxt       = GRANT1;
                    last_served_nxt = 1'b1;
                end
            end
            GRANT0: begin
                ready0 = !bus.fifo_full && !n_rst;
                xfer   = bus.req0_valid && ready0;
                wdata  = bus.req0_data;
                if (xfer) begin
                    beat_nxt = beat_inc;
                    if (bus.req0_last || (beat_inc == BURST_LAST)) begin
                        state_nxt = IDLE;
                        beat_nxt  = 8'd0;
                    end
                end else if (!bus.req0_valid) begin
                    state_nxt = IDLE;
                    beat_nxt  = 8'd0;
                end
            end
            GRANT1: begin
                ready1 = !bus.fifo_full && !n_rst;
                xfer   = bus.req1_valid && ready1;
                wdata  = bus.req1_data;
                if (xfer) begin
                    beat_nxt = beat_inc;
                    if (bus.req1_last || (beat_inc == BURST_LAST)) begin
                        state_nxt = IDLE;
                        beat_nxt  = 8'd0;
                    end
                end else if (!bus.req1_valid) begin
                    state_nxt = IDLE;
                    beat_nxt  = 8'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                beat_nxt  = 8'd0;
            end
        endcase
    end

    assign bus.req0_ready    = ready0;
    assign bus.req1_ready    = ready1;
    assign bus.fifo_w_enable = xfer;
    assign bus.fifo_w_data   = wdata;
    assign bus.grant         = state;

`ifdef FIFO_ARB_STATS_EN
    logic [CNT_W-1:0] stat0, stat1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (n_rst) begin
            stat0 <= '0;
            stat1 <= '0;
        end else begin
            if (xfer && (state == GRANT0)) stat0 <= sat_inc(stat0);
            if (xfer && (state == GRANT1)) stat1 <= sat_inc(stat1);
        end
    end

    assign bus.stat0_bytes = stat0;
    assign bus.stat1_bytes = stat1;
`else
    assign bus.stat0_bytes = '0;
    assign bus.stat1_bytes = '0;
`endif
endmodule

// File: tb/tb_rx_fifo_arbiter.sv
// Directed self-checking bench for rx_fifo_arbiter, built with BURST_LEN=4.
module tb_rx_fifo_arbiter;
    localparam int BL = 4;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic n_rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rx_fifo_arbiter_if #(.CNT_W(CW)) bus ();

    rx_fifo_arbiter #(.BURST_LEN(BL), .CNT_W(CW)) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_data = 8'h00; bus.req0_last = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_data = 8'h00; bus.req1_last = 1'b0;
        bus.fifo_full  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        n_rst = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        step(); step();
        to_neg();
        checks++; if (bus.grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b want=00", bus.grant); end
        checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b%b want=00", bus.req0_ready, bus.req1_ready); end
        checks++; if (bus.fifo_w_enable !== 1'b0) begin failures++; $display("FAIL reset_wen got=%b want=0", bus.fifo_w_enable); end
        checks++; if (bus.fifo_w_data !== 8'h00) begin failures++; $display("FAIL reset_wdata got=%h want=00", bus.fifo_w_data); end
        step();
        n_rst = 1'b0;
        idle_inputs();
        to_neg();
        checks++; if (bus.grant !== 2'b00) begin failures++; $display("FAIL reset_idle_grant got=%b want=00", bus.grant); end
        step();
    endtask

    task automatic test_single_packet();
        logic [7:0] bytes [3] = '{8'hA1, 8'hA2, 8'hA3};
        bus.req0_valid = 1'b1; bus.req0_data = bytes[0]; bus.req0_last = 1'b0;
        to_neg();
        checks++; if (bus.grant !== 2'b00 || bus.fifo_w_enable !== 1'b0) begin failures++; $display("FAIL single_arb_latency got grant=%b wen=%b want 00/0", bus.grant, bus.fifo_w_enable); end
        for (int i = 0; i < 3; i++) begin
            step();
            bus.req0_data = bytes[i];
            bus.req0_last = (i == 2);
            to_neg();
            checks++; if (bus.grant !== 2'b01) begin failures++; $display("FAIL single_grant beat%0d got=%b want=01", i, bus.grant); end
            checks++; if (bus.fifo_w_enable !== 1'b1 || bus.fifo_w_data !== bytes[i]) begin failures++; $display("FAIL single_write beat%0d got wen=%b data=%h want 1/%h", i, bus.fifo_w_enable, bus.fifo_w_data, bytes[i]); end
            checks++; if (bus.req1_ready !== 1'b0) begin failures++; $display("FAIL single_other_ready beat%0d got=%b want=0", i, bus.req1_ready); end
        end
        step();
        bus.req0_valid = 1'b0; bus.req0_last = 1'b0;
        to_neg();
        checks++; if (bus.grant !== 2'b00 || bus.fifo_w_enable !== 1'b0) begin failures++; $display("FAIL single_release got grant=%b wen=%b want 00/0", bus.grant, bus.fifo_w_enable); end
        step();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [15] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10,
                                   2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
        logic [7:0] exp_d [15] = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h00, 8'h20, 8'h21, 8'h22, 8'h23,
                                   8'h00, 8'h14, 8'h15, 8'h16, 8'h17};
        logic adv0, adv1;
        n_rst = 1'b1;
        step();
        n_rst = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_data = 8'h10;
        bus.req1_valid = 1'b1; bus.req1_data = 8'h20;
        for (int c = 0; c < 15; c++) begin
            to_neg();
            checks++; if (bus.grant !== exp_g[c]) begin failures++; $display("FAIL rr_grant c%0d got=%b want=%b", c, bus.grant, exp_g[c]); end
            checks++; if (bus.fifo_w_enable !== (exp_g[c] != 2'b00)) begin failures++; $display("FAIL rr_wen c%0d got=%b want=%b", c, bus.fifo_w_enable, (exp_g[c] != 2'b00)); end
            if (exp_g[c] != 2'b00) begin
                checks++; if (bus.fifo_w_data !== exp_d[c]) begin failures++; $display("FAIL rr_data c%0d got=%h want=%h", c, bus.fifo_w_data, exp_d[c]); end
            end
            adv0 = bus.req0_valid && bus.req0_ready;
            adv1 = bus.req1_valid && bus.req1_ready;
            step();
            if (adv0) bus.req0_data = bus.req0_data + 8'd1;
            if (adv1) bus.req1_data = bus.req1_data + 8'd1;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        to_neg();
        checks++; if (bus.grant !== 2'b00) begin failures++; $display("FAIL rr_end_release got=%b want=00", bus.grant); end
        step();
    endtask

    task automatic test_full_hold();
        bus.req1_valid = 1'b1; bus.req1_data = 8'h30; bus.req1_last = 1'b0;
        to_neg();
        step();
        to_neg();
        checks++; if (bus.grant !== 2'b10 || bus.fifo_w_data !== 8'h30 || bus.fifo_w_enable !== 1'b1) begin failures++; $display("FAIL full_first got grant=%b wen=%b data=%h want 10/1/30", bus.grant, bus.fifo_w_enable, bus.fifo_w_data); end
        step();
        bus.req1_data = 8'h31;
        bus.fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            to_neg();
            checks++; if (bus.req1_ready !== 1'b0 || bus.fifo_w_enable !== 1'b0) begin failures++; $display("FAIL full_stall k%0d got ready=%b wen=%b want 0/0", k, bus.req1_ready, bus.fifo_w_enable); end
            checks++; if (bus.grant !== 2'b10) begin failures++; $display("FAIL full_hold_grant k%0d got=%b want=10", k, bus.grant); end
            step();
            if (k == 4) bus.fifo_full = 1'b0;
        end
        for (int j = 0; j < 3; j++) begin
            to_neg();
            checks++; if (bus.grant !== 2'b10 || bus.fifo_w_enable !== 1'b1 || bus.fifo_w_data !== 8'(8'h31 + j)) begin failures++; $display("FAIL full_resume j%0d got grant=%b wen=%b data=%h want 10/1/%h", j, bus.grant, bus.fifo_w_enable, bus.fifo_w_data, 8'(8'h31 + j)); end
            step();
            bus.req1_data = bus.req1_data + 8'd1;
        end
        bus.req1_valid = 1'b0;
        to_neg();
        checks++; if (bus.grant !== 2'b00) begin failures++; $display("FAIL full_burst_limit got=%b want=00", bus.grant); end
        step();
    endtask

    task automatic test_valid_drop();
        bus.req0_valid = 1'b1; bus.req0_data = 8'h40;
        bus.req1_valid = 1'b1; bus.req1_data = 8'h50;
        to_neg();
        step();
        to_neg();
        checks++; if (bus.grant !== 2'b01 || bus.fifo_w_data !== 8'h40 || bus.req1_ready !== 1'b0) begin failures++; $display("FAIL drop_first got grant=%b data=%h r1=%b want 01/40/0", bus.grant, bus.fifo_w_data, bus.req1_ready); end
        step();
        bus.req0_data = 8'h41;
        to_neg();
        checks++; if (bus.fifo_w_enable !== 1'b1 || bus.fifo_w_data !== 8'h41) begin failures++; $display("FAIL drop_second got wen=%b data=%h want 1/41", bus.fifo_w_enable, bus.fifo_w_data); end
        step();
        bus.req0_valid = 1'b0;
        to_neg();
        checks++; if (bus.grant !== 2'b01 || bus.fifo_w_enable !== 1'b0) begin failures++; $display("FAIL drop_novalid got grant=%b wen=%b want 01/0", bus.grant, bus.fifo_w_enable); end
        step();
        to_neg();
        checks++; if (bus.grant !== 2'b00) begin failures++; $display("FAIL drop_release got=%b want=00", bus.grant); end
        step();
        to_neg();
        checks++; if (bus.grant !== 2'b10 || bus.fifo_w_data !== 8'h50 || bus.fifo_w_enable !== 1'b1) begin failures++; $display("FAIL drop_port1 got grant=%b wen=%b data=%h want 10/1/50", bus.grant, bus.fifo_w_enable, bus.fifo_w_data); end
        step();
        bus.req1_valid = 1'b0;
        step(); step();
    endtask

    task automatic test_last_at_limit();
        bus.req0_valid = 1'b1; bus.req0_data = 8'h80; bus.req0_last = 1'b0;
        to_neg();
        for (int i = 0; i < 4; i++) begin
            step();
            bus.req0_data = 8'(8'h80 + i);
            bus.req0_last = (i == 3);
            to_neg();
            checks++; if (bus.grant !== 2'b01 || bus.fifo_w_data !== 8'(8'h80 + i)) begin failures++; $display("FAIL lastlim_beat%0d got grant=%b data=%h want 01/%h", i, bus.grant, bus.fifo_w_data, 8'(8'h80 + i)); end
        end
        step();
        bus.req0_data = 8'h84; bus.req0_last = 1'b0;
        to_neg();
        checks++; if (bus.grant !== 2'b00) begin failures++; $display("FAIL lastlim_bubble got=%b want=00", bus.grant); end
        step();
        to_neg();
        checks++; if (bus.grant !== 2'b01 || bus.fifo_w_data !== 8'h84) begin failures++; $display("FAIL lastlim_regrant got grant=%b data=%h want 01/84", bus.grant, bus.fifo_w_data); end
        step();
        bus.req0_valid = 1'b0;
        step(); step();
    endtask

    task automatic test_reset_midburst();
        bus.req0_valid = 1'b1; bus.req0_data = 8'h60;
        to_neg();
        step();
        to_neg();
        checks++; if (bus.fifo_w_data !== 8'h60 || bus.fifo_w_enable !== 1'b1) begin failures++; $display("FAIL rstmid_beat0 got wen=%b data=%h want 1/60", bus.fifo_w_enable, bus.fifo_w_data); end
        step();
        bus.req0_data = 8'h61;
        step();
        bus.req0_data = 8'h62;
        n_rst = 1'b1;
        to_neg();
        checks++; if (bus.fifo_w_enable !== 1'b0 || bus.req0_ready !== 1'b0) begin failures++; $display("FAIL rstmid_gated got wen=%b ready=%b want 0/0", bus.fifo_w_enable, bus.req0_ready); end
        step();
        n_rst = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_data = 8'h70;
        to_neg();
        checks++; if (bus.grant !== 2'b00 || bus.fifo_w_enable !== 1'b0) begin failures++; $display("FAIL rstmid_dropped got grant=%b wen=%b want 00/0", bus.grant, bus.fifo_w_enable); end
        step();
        to_neg();
        checks++; if (bus.grant !== 2'b01 || bus.fifo_w_data !== 8'h62) begin failures++; $display("FAIL rstmid_port0_first got grant=%b data=%h want 01/62", bus.grant, bus.fifo_w_data); end
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        step(); step();
    endtask

    task automatic test_stats();
        int rem0, rem1, wr, cyc;
        logic adv0, adv1;
        n_rst = 1'b1;
        step();
        n_rst = 1'b0;
        rem0 = 10; rem1 = 7; wr = 0; cyc = 0;
        bus.req0_data = 8'h90; bus.req1_data = 8'hB0;
        while ((rem0 > 0 || rem1 > 0) && cyc < 200) begin
            bus.req0_valid = (rem0 > 0);
            bus.req1_valid = (rem1 > 0);
            to_neg();
            if (bus.fifo_w_enable === 1'b1) wr++;
            adv0 = bus.req0_valid && bus.req0_ready;
            adv1 = bus.req1_valid && bus.req1_ready;
            if (adv0) rem0--;
            if (adv1) rem1--;
            step();
            if (adv0) bus.req0_data = bus.req0_data + 8'd1;
            if (adv1) bus.req1_data = bus.req1_data + 8'd1;
            cyc++;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        checks++; if (rem0 != 0 || rem1 != 0) begin failures++; $display("FAIL stats_timeout got rem0=%0d rem1=%0d want 0/0", rem0, rem1); end
        checks++; if (wr != 17) begin failures++; $display("FAIL stats_writes got=%0d want=17", wr); end
        step();
        to_neg();
`ifdef FIFO_ARB_STATS_EN
        checks++; if (bus.stat0_bytes !== CW'(10)) begin failures++; $display("FAIL stat0 got=%0d want=10", bus.stat0_bytes); end
        checks++; if (bus.stat1_bytes !== CW'(7)) begin failures++; $display("FAIL stat1 got=%0d want=7", bus.stat1_bytes); end
`else
        checks++; if (bus.stat0_bytes !== '0) begin failures++; $display("FAIL stat0 got=%0d want=0", bus.stat0_bytes); end
        checks++; if (bus.stat1_bytes !== '0) begin failures++; $display("FAIL stat1 got=%0d want=0", bus.stat1_bytes); end
`endif
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b1;
        idle_inputs();
        step();
        test_reset();
        test_single_packet();
        test_round_robin();
        test_full_hold();
        test_valid_drop();
        test_last_at_limit();
        test_reset_midburst();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
